uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Byte queue that sits directly upstream of the UART transmitter and serialises bursts from flight-control logic (telemetry, debug prints) into the transmitter's one-byte send/complete handshake. It absorbs up to DEPTH bytes, presents one byte at a time on txData/txSend, and waits for the transmitter's completion pulse before releasing the next. After reset it holds off for one full UART frame, so a byte still in flight in the transmitter cannot be mistaken for a completion.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥2.
- CLKS_PER_BIT, 139: must match the transmitter's bit period in clocks.
- HOLDOFF_CLKS, CLKS_PER_BIT*11: post-reset quiet period (10-bit frame plus one bit of margin).

Ports:
- clock  in  1  system clock; all logic on posedge.
- resetN  in  1  asynchronous, active-low reset.
- wrData  in  8  byte to enqueue.
- wrEn  in  1  enqueue strobe; one byte per cycle.
- full  out  1  FIFO holds DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse when wrEn is rejected.
- txData  out  8  byte to the transmitter's txIn.
- txSend  out  1  to the transmitter's send.
- txComplete  in  1  from the transmitter's sendComplete.
- busy  out  1  high when the state is not IDLE or when empty is 0.

## Operation
- Reset values: full=0, empty=1, level=0, overflow=0, txData=8'h00, txSend=0, busy=1, state=HOLDOFF, holdoff counter=0.
- FIFO: registered read/write pointers with one extra wrap bit each; level = wrPtr − rdPtr, modulo 2^($clog2(DEPTH)+1).
- Rejected write: wrEn while full is dropped and produces an overflow pulse. This applies even when a pop happens in the same cycle.
- Simultaneous wrEn and pop while not full: both take effect, and level is unchanged.
- State HOLDOFF: txSend=0. The counter runs from 0 to HOLDOFF_CLKS−1, then the state goes to IDLE. wrEn is accepted during HOLDOFF.
- State IDLE: if empty=0, then on this edge the FIFO head goes to txData, rdPtr advances, txSend becomes 1, and the state goes to SEND. If empty=1, the state stays IDLE.
- State SEND: txSend=1 and txData is held stable. When txComplete=1, txSend becomes 0 on that edge and the state goes to RELEASE.
- State RELEASE: txSend=0. When txComplete=0, the state goes to IDLE. This guarantees the transmitter has returned to listening before the next send.
- txData is held until the next load; it is never cleared except by reset.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously) and queued bytes are discarded. A byte already on the line finishes within HOLDOFF_CLKS.

## Timing
- Write to empty queue in IDLE: wrEn at edge N → empty=0 after N. Pop at edge N+1, with txSend=1 and txData valid after N+1.
- Per-byte overhead beyond the transmitter frame: 1 cycle in RELEASE plus 1 cycle in IDLE.
- txComplete=1 sampled at edge M → txSend=0 after M.
- Next txSend: no earlier than two edges after txComplete is first sampled 0.
- full, empty, level and overflow are registered and update on the same edge as the write or pop.
- busy is combinational from state and empty.

## Structure
- Shared package uart_pkg holds:
  - state encodings HOLDOFF, IDLE, SEND, RELEASE (2-bit);
  - the UART_FRAME_BITS=10 constant used to derive HOLDOFF_CLKS.
- One sub-module, byte_fifo:
  - parameterised by DEPTH;
  - ports: push, pop, din, dout (head, first-word-fall-through), full, empty, level, overflow.
- The sequencer FSM and holdoff counter live in uart_tx_queue.
- Integration: instantiate alongside uart_tx with txData→txIn, txSend→send, sendComplete→txComplete.

## Test plan
- Reset, then 5 idle cycles → txSend=0, empty=1, level=0, busy=1.
- After the holdoff expires, write 0xA5 → txSend rises 1 cycle later with txData=0xA5. The serial line shows start bit, 1,0,1,0,0,1,0,1 (LSB first), stop bit, with each bit lasting CLKS_PER_BIT clocks.
- Burst of 16 bytes 0x00..0x0F in consecutive cycles → full=1 and level=16. A 17th write gives overflow=1 for one cycle and level stays 16. The line shows 0x00..0x0F in order, with no duplicates or gaps.
- At full, wrEn in the same cycle as a pop → write rejected with overflow=1 and level=15.
- Reset asserted mid-frame with 3 bytes queued → txSend=0 immediately and level=0. No txSend during HOLDOFF_CLKS. A new byte 0x3C written afterwards is transmitted intact.
- Model a transmitter that holds txComplete=1 for 4 cycles → txSend drops on the first of those cycles, and the next byte is not sent until txComplete=0 has been observed.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: sequencer states and frame constants.
package uart_pkg;

  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    HOLDOFF = 2'd0,
    IDLE    = 2'd1,
    SEND    = 2'd2,
    RELEASE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO with wrap-bit pointers and a registered
// overflow pulse for writes rejected while full.
module byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          resetN,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        overflow_q;
  logic        do_push_s;
  logic        do_pop_s;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == DEPTH_L);
  assign empty    = (level == {(AW+1){1'b0}});
  assign dout     = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow = overflow_q;

  // A full queue rejects the write even if a pop frees a slot on the same edge.
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array: written only on accepted pushes.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  // Pointer and overflow registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q   <= {(AW+1){1'b0}};
      rd_ptr_q   <= {(AW+1){1'b0}};
      overflow_q <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + ONE_L;
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + ONE_L;
      end
      overflow_q <= push && full;
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter through its send/complete handshake,
// with a post-reset quiet period covering a frame that may still be in flight.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter  int DEPTH        = 16,
  parameter  int CLKS_PER_BIT = 139,
  parameter  int HOLDOFF_CLKS = CLKS_PER_BIT * (UART_FRAME_BITS + 1),
  localparam int LW           = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          resetN,
  input  logic [7:0]    wrData,
  input  logic          wrEn,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          overflow,
  output logic [7:0]    txData,
  output logic          txSend,
  input  logic          txComplete,
  output logic          busy
);

  localparam int          HW        = (HOLDOFF_CLKS > 1) ? $clog2(HOLDOFF_CLKS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CLKS - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  tx_state_e     state_q;
  logic [HW-1:0] holdoff_cnt_q;
  logic [7:0]    tx_data_q;
  logic          tx_send_q;
  logic [7:0]    head_s;
  logic          empty_s;
  logic          pop_s;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .resetN   (resetN),
    .push     (wrEn),
    .pop      (pop_s),
    .din      (wrData),
    .dout     (head_s),
    .full     (full),
    .empty    (empty_s),
    .level    (level),
    .overflow (overflow)
  );

  assign pop_s  = (state_q == IDLE) && !empty_s;
  assign empty  = empty_s;
  assign busy   = (state_q != IDLE) || !empty_s;
  assign txData = tx_data_q;
  assign txSend = tx_send_q;

  // Sequencer: holdoff timer, head load, and the send/complete/release handshake.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= HOLDOFF;
      holdoff_cnt_q <= {HW{1'b0}};
      tx_data_q     <= 8'h00;
      tx_send_q     <= 1'b0;
    end else begin
      case (state_q)
        HOLDOFF: begin
          tx_send_q <= 1'b0;
          if (holdoff_cnt_q == HOLD_LAST) begin
            holdoff_cnt_q <= {HW{1'b0}};
            state_q       <= IDLE;
          end else begin
            holdoff_cnt_q <= holdoff_cnt_q + HOLD_ONE;
          end
        end
        IDLE: begin
          if (!empty_s) begin
            tx_data_q <= head_s;
            tx_send_q <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (txComplete) begin
            tx_send_q <= 1'b0;
            state_q   <= RELEASE;
          end
        end
        // Wait for complete to drop so a long pulse is not read as a second completion.
        RELEASE: begin
          tx_send_q <= 1'b0;
          if (!txComplete) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q       <= HOLDOFF;
          holdoff_cnt_q <= {HW{1'b0}};
          tx_send_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: behavioural transmitter, serial-line
// receiver and an expected-byte scoreboard.
module tb_uart_tx_queue;

  localparam int DEPTH   = 16;
  localparam int CPB     = 8;
  localparam int HOLDOFF = CPB * 11;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          tx_complete;
  logic          busy;

  logic          tx_line;
  int            comp_len;
  int            n_cmp;
  int            n_mis;
  logic [7:0]    exp_q [$];

  uart_tx_queue #(
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clock      (clk),
    .resetN     (rst_n),
    .wrData     (wr_data),
    .wrEn       (wr_en),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .txData     (tx_data),
    .txSend     (tx_send),
    .txComplete (tx_complete),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] d, input bit expect_accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (expect_accept) exp_q.push_back(d);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n = n + 1;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    repeat (CPB * 2) tick();
  endtask

  // Transmitter model: serialises a byte per send, then pulses complete for comp_len cycles.
  initial begin
    logic [9:0] frame;
    tx_line     = 1'b1;
    tx_complete = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_send === 1'b1) begin
        frame = {1'b1, tx_data, 1'b0};
        for (int b = 0; b < 10; b++) begin
          tx_line = frame[b];
          repeat (CPB) @(posedge clk);
          #1;
        end
        tx_line     = 1'b1;
        tx_complete = 1'b1;
        for (int c = 0; c < comp_len; c++) begin
          @(posedge clk);
          #1;
          chk("send_low_during_complete", 32'(tx_send), 32'd0);
        end
        tx_complete = 1'b0;
        @(posedge clk);
        #1;
        chk("send_low_after_release", 32'(tx_send), 32'd0);
      end
    end
  end

  // Line receiver: centre-samples each frame and retires the oldest expected byte.
  initial begin
    logic [7:0] rx;
    forever begin
      @(posedge clk);
      #3;
      if (tx_line === 1'b0) begin
        repeat (CPB / 2) @(posedge clk);
        #3;
        chk("rx_start_bit", 32'(tx_line), 32'd0);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(posedge clk);
          #3;
          rx[b] = tx_line;
        end
        repeat (CPB) @(posedge clk);
        #3;
        chk("rx_stop_bit", 32'(tx_line), 32'd1);
        if (exp_q.size() == 0) begin
          chk("rx_unexpected_byte", 32'(rx), 32'hFFFF_FFFF);
        end else begin
          chk("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int  n;
    bit  saw_send;
    n_cmp    = 0;
    n_mis    = 0;
    comp_len = 1;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_txsend", 32'(tx_send), 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'h00);
    repeat (3) tick();
    rst_n = 1'b1;

    // Quiet period after reset
    repeat (5) tick();
    chk("idle5_txsend", 32'(tx_send), 32'd0);
    chk("idle5_empty",  32'(empty),   32'd1);
    chk("idle5_level",  32'(level),   32'd0);
    chk("idle5_busy",   32'(busy),    32'd1);
    chk("idle5_ovf",    32'(overflow), 32'd0);
    repeat (HOLDOFF - 1 - 5) tick();
    chk("holdoff_last_busy", 32'(busy), 32'd1);
    tick();
    chk("holdoff_done_busy", 32'(busy), 32'd0);

    // First byte latency
    wr(8'hA5, 1'b1);
    chk("a5_empty",  32'(empty),   32'd0);
    chk("a5_level",  32'(level),   32'd1);
    chk("a5_send0",  32'(tx_send), 32'd0);
    tick();
    chk("a5_send1",  32'(tx_send), 32'd1);
    chk("a5_data",   32'(tx_data), 32'hA5);
    chk("a5_level0", 32'(level),   32'd0);

    // Burst to full while A5 is on the line, then one rejected write
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      exp_q.push_back(8'(i));
      tick();
    end
    chk("burst_full",  32'(full),     32'd1);
    chk("burst_level", 32'(level),    32'd16);
    chk("burst_ovf0",  32'(overflow), 32'd0);
    wr(8'h10, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level),    32'd16);
    tick();
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Write aligned with the pop that follows A5's release
    n = 0;
    while (tx_complete !== 1'b1 && n < 2000) begin tick(); n = n + 1; end
    chk("wait_complete_hi", 32'(tx_complete), 32'd1);
    n = 0;
    while (tx_complete !== 1'b0 && n < 100) begin tick(); n = n + 1; end
    chk("wait_complete_lo", 32'(tx_complete), 32'd0);
    tick();
    wr(8'hEE, 1'b0);
    chk("fullpop_ovf",   32'(overflow), 32'd1);
    chk("fullpop_level", 32'(level),    32'd15);
    chk("fullpop_send",  32'(tx_send),  32'd1);
    chk("fullpop_data",  32'(tx_data),  32'h00);
    wait_drain("drain_burst", 4000);
    chk("drained_busy", 32'(busy), 32'd0);

    // Long completion pulse; simultaneous push and pop keeps level
    comp_len = 4;
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b1);
    chk("pushpop_level", 32'(level), 32'd1);
    wait_drain("drain_long_complete", 1000);
    comp_len = 1;

    // Reset in the middle of a frame with three bytes queued
    wr(8'h40, 1'b1);
    wr(8'h41, 1'b1);
    wr(8'h42, 1'b1);
    wr(8'h43, 1'b1);
    chk("queued3_level", 32'(level), 32'd3);
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_send",  32'(tx_send), 32'd0);
    chk("midrst_level", 32'(level),   32'd0);
    chk("midrst_empty", 32'(empty),   32'd1);
    chk("midrst_busy",  32'(busy),    32'd1);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    tick();
    rst_n    = 1'b1;
    wr_en    = 1'b1;
    wr_data  = 8'h3C;
    exp_q.push_back(8'h3C);
    saw_send = 1'b0;
    for (int i = 1; i <= HOLDOFF; i++) begin
      tick();
      wr_en = 1'b0;
      if (tx_send === 1'b1) saw_send = 1'b1;
      if (i == 1) chk("holdoff_write_level", 32'(level), 32'd1);
    end
    chk("holdoff_no_send", 32'(saw_send), 32'd0);
    tick();
    chk("post_holdoff_send", 32'(tx_send), 32'd1);
    chk("post_holdoff_data", 32'(tx_data), 32'h3C);
    wait_drain("drain_after_reset", 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
